// File: rtl/jk_counter_pkg.sv
// jk_counter_pkg: direction constants and the JK excitation helper shared by jk_mod_counter
package jk_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic [1:0] jk_excite(input logic nxt, input logic q);
    return {nxt & ~q, ~nxt & q};
  endfunction
endpackage

// File: rtl/flip_flop_jk_type.sv
// flip_flop_jk_type: single JK flip-flop, async active-low reset
//   clk_i  rising-edge clock
//   rst_ni async reset, clears q_o
//   j_i/k_i 00 hold, 01 clear, 10 set, 11 toggle
//   q_o    stored bit
module flip_flop_jk_type (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_o <= 1'b0;
    else q_o <= (j_i & ~q_o) | (~k_i & q_o);
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULO up/down counter built from one JK flip-flop per bit
//   clk_i      rising-edge clock
//   rst_ni     async active-low reset, clears count and sticky flags
//   en_i       step enable
//   up_i       direction, DIR_UP counts up, DIR_DOWN counts down
//   load_i     synchronous load, priority over en_i
//   d_i        load value, out-of-range values load 0 and flag load_err_o
//   count_o    present count (flip-flop Q bus)
//   tc_o       combinational terminal count at the wrap point of the enabled step
//   wrapped_o  sticky, set on a wrap edge
//   load_err_o sticky, set when an out-of-range load is accepted
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrapped_o,
  output logic             load_err_o
);
  // compare at WIDTH+1 bits so MODULO = 2**WIDTH stays representable
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   LAST_W = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  logic [WIDTH-1:0] nxt_d, j, k;
  logic at_last, at_zero, past_last, load_ok, wrapped_q, load_err_q;
  assign at_last   = {1'b0, count_o} == LAST_W;
  assign at_zero   = count_o == '0;
  assign past_last = {1'b0, count_o} > LAST_W;
  assign load_ok   = {1'b0, d_i} < MOD_W;
  // tc marks exactly the edge that wraps, so it doubles as the wrap event
  assign tc_o = en_i & ~load_i & (up_i == DIR_UP ? at_last : at_zero);
  // an illegal count recovers to 0 going up and to LAST going down
  always_comb
    nxt_d = load_i ? (load_ok ? d_i : '0) :
            !en_i ? count_o :
            up_i == DIR_DOWN ? (at_zero | past_last ? LAST : count_o - ONE) :
            (at_last | past_last ? '0 : count_o + ONE);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j[i], k[i]} = jk_excite(nxt_d[i], count_o[i]);
    flip_flop_jk_type u_ff (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .j_i    (j[i]),
      .k_i    (k[i]),
      .q_o    (count_o[i])
    );
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrapped_q  <= wrapped_q | tc_o;
      load_err_q <= load_err_q | (load_i & ~load_ok);
    end
  assign wrapped_o  = wrapped_q;
  assign load_err_o = load_err_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed table-driven bench for jk_mod_counter (MODULO 10 and 16)
module tb_jk_mod_counter;
  typedef struct {
    logic ld, en, up;
    logic [3:0] d;
    logic tc;
    logic [3:0] cnt;
    logic wr, le;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ld = 1'b0, en = 1'b0, up = 1'b1;
  logic [3:0] d = '0, cnt;
  logic tc, wr, le;
  logic ld16 = 1'b0, en16 = 1'b0, up16 = 1'b1;
  logic [3:0] d16 = '0, cnt16;
  logic tc16, wr16, le16;
  int checks = 0, failures = 0, jk_bad = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .load_i(ld), .d_i(d),
    .count_o(cnt), .tc_o(tc), .wrapped_o(wr), .load_err_o(le));
  jk_mod_counter #(.WIDTH(4), .MODULO(16)) u16 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en16), .up_i(up16), .load_i(ld16), .d_i(d16),
    .count_o(cnt16), .tc_o(tc16), .wrapped_o(wr16), .load_err_o(le16));
  always @(negedge clk)
    if (((dut.j & dut.k) != '0) || ((u16.j & u16.k) != '0)) jk_bad++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic l, e, u, input logic [3:0] dv, input logic t,
                     input logic [3:0] c, input logic w, input logic x);
    v.push_back('{ld: l, en: e, up: u, d: dv, tc: t, cnt: c, wr: w, le: x});
  endtask
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ld = v[i].ld; en = v[i].en; up = v[i].up; d = v[i].d;
      #1 chk($sformatf("v%0d_tc", i), tc, v[i].tc);
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i), cnt, v[i].cnt);
      chk($sformatf("v%0d_wrapped", i), wr, v[i].wr);
      chk($sformatf("v%0d_load_err", i), le, v[i].le);
    end
  endtask
  initial begin
    for (int i = 1; i <= 12; i++)
      add(0, 1, 1, 0, ((i - 1) % 10) == 9, 4'(i % 10), i >= 10, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 9, 1, 0);
    add(0, 1, 0, 0, 0, 8, 1, 0);
    add(1, 1, 1, 6, 0, 6, 1, 0);
    add(1, 0, 1, 12, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) add(0, 1, 1, 0, 0, 4'(i), 1, 1);
    add(0, 1, 1, 0, 0, 5, 1, 1);
    add(0, 1, 0, 0, 0, 4, 1, 1);
    add(0, 1, 0, 0, 0, 3, 1, 1);
    add(1, 0, 1, 9, 0, 9, 1, 1);
    add(0, 0, 1, 0, 0, 9, 1, 1);
    add(0, 1, 1, 0, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1, 9, 1, 1);
    add(1, 1, 1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 10, 0, 0, 1, 1);
    add(1, 0, 1, 9, 0, 9, 1, 1);
    #20 rst_n = 1'b1;
    #2;
    chk("rst_count", cnt, 0);
    chk("rst_wrapped", wr, 0);
    chk("rst_load_err", le, 0);
    chk("rst_tc", tc, 0);
    @(posedge clk); #1;
    run_vecs(0, 12);
    ld = 1'b1; en = 1'b0; d = 4'd7;
    @(posedge clk); #1;
    chk("load7_count", cnt, 7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", cnt, 0);
    chk("async_rst_wrapped", wr, 0);
    chk("async_rst_load_err", le, 0);
    #3 rst_n = 1'b1;
    run_vecs(12, 22);
    ld = 1'b0; en = 1'b0; up = 1'b1;
    repeat (5) begin
      #1;
      chk("hold_j", dut.j, 0);
      chk("hold_k", dut.k, 0);
      chk("hold_tc", tc, 0);
      @(posedge clk); #1;
      chk("hold_count", cnt, 4);
    end
    run_vecs(22, v.size());
    ld16 = 1'b1; d16 = 4'd15;
    @(posedge clk); #1;
    chk("m16_load15_count", cnt16, 15);
    chk("m16_load15_err", le16, 0);
    chk("m16_pre_wrapped", wr16, 0);
    ld16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
    #1 chk("m16_tc_up", tc16, 1);
    @(posedge clk); #1;
    chk("m16_wrap_count", cnt16, 0);
    chk("m16_wrapped", wr16, 1);
    up16 = 1'b0;
    #1 chk("m16_tc_down", tc16, 1);
    @(posedge clk); #1;
    chk("m16_down_count", cnt16, 15);
    chk("m16_load_err_final", le16, 0);
    en16 = 1'b0;
    @(negedge clk);
    chk("jk_toggle_never", jk_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
